// File: rtl/sentinel_pkg.sv
// Shared types and constants for the sentinel sequence lock: FSM states,
// active-low 7-segment glyphs ({dp,g,f,e,d,c,b,a}) and a parameter sanity check.
package sentinel_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_e;

    localparam logic [7:0] SegOff      = 8'hFF;
    localparam logic [7:0] SegLocked   = 8'hC7;
    localparam logic [7:0] SegCollect  = 8'hBF;
    localparam logic [7:0] SegVerified = 8'hC1;
    localparam logic [7:0] SegLockout  = 8'h8E;

    function automatic bit params_ok(input int unsigned key_w,
                                     input int unsigned seq_len,
                                     input int unsigned max_fail,
                                     input int unsigned lockout_cyc);
        return (key_w >= 1) && (seq_len >= 1) && (max_fail >= 1) && (lockout_cyc >= 1);
    endfunction

endpackage

// File: rtl/sentinel_timer.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count holds at zero.
module sentinel_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/sentinel_seq_lock.sv
// Multi-entry key-sequence lock with failure counting, timed lockout and
// optional auto-relock; drives the active-low 7-segment display.
module sentinel_seq_lock
    import sentinel_pkg::*;
#(
    parameter int unsigned                KEY_W       = 8,
    parameter int unsigned                SEQ_LEN     = 4,
    parameter logic [KEY_W*SEQ_LEN-1:0]   KEY_SEQ     = 32'h5AA5_3CB6,
    parameter int unsigned                MAX_FAIL    = 3,
    parameter int unsigned                LOCKOUT_CYC = 1024,
    parameter int unsigned                UNLOCK_CYC  = 0,
    localparam int unsigned               FAIL_W      = $clog2(MAX_FAIL + 1),
    localparam int unsigned               IDX_W       = $clog2(SEQ_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_valid,
    input  logic              relock,
    output logic [7:0]        seg_out,
    output logic              unlocked,
    output logic              lockout,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic [IDX_W-1:0]  seq_idx
);

    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYC + 1);

    if (!params_ok(KEY_W, SEQ_LEN, MAX_FAIL, LOCKOUT_CYC)) begin : g_bad_params
        $error("sentinel_seq_lock: KEY_W, SEQ_LEN, MAX_FAIL and LOCKOUT_CYC must all be >= 1");
    end

    state_e            state, state_nx;
    logic [IDX_W-1:0]  idx_nx;
    logic [FAIL_W-1:0] fail_nx;
    logic              mismatch, mismatch_nx;
    logic              lko_load, unl_load;
    logic              lko_zero, unl_zero;
    logic [KEY_W-1:0]  exp_key_c;
    logic              key_bad_c;
    logic              last_c;

    // Expected entry for the current position (seq_idx is 0 while LOCKED)
    always_comb begin
        exp_key_c = '0;
        for (int unsigned i = 0; i < SEQ_LEN; i++) begin
            if (seq_idx == IDX_W'(i)) exp_key_c = KEY_SEQ[i*KEY_W +: KEY_W];
        end
    end

    assign key_bad_c = (key_in != exp_key_c);
    assign last_c    = (seq_idx == IDX_W'(SEQ_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_LOCKED;
            seq_idx  <= '0;
            fail_cnt <= '0;
            mismatch <= 1'b0;
        end else begin
            state    <= state_nx;
            seq_idx  <= idx_nx;
            fail_cnt <= fail_nx;
            mismatch <= mismatch_nx;
        end
    end

    // Every entry is consumed before judging so timing never reveals the bad position
    always_comb begin
        state_nx    = state;
        idx_nx      = seq_idx;
        fail_nx     = fail_cnt;
        mismatch_nx = mismatch;
        lko_load    = 1'b0;
        unl_load    = 1'b0;
        case (state)
            ST_LOCKED, ST_COLLECT: begin
                if (relock || !ena) begin
                    state_nx    = ST_LOCKED;
                    idx_nx      = '0;
                    mismatch_nx = 1'b0;
                end else if (key_valid) begin
                    if (last_c) begin
                        idx_nx      = '0;
                        mismatch_nx = 1'b0;
                        if (!(mismatch || key_bad_c)) begin
                            state_nx = ST_UNLOCKED;
                            fail_nx  = '0;
                            unl_load = 1'b1;
                        end else if (32'(fail_cnt) + 32'd1 < MAX_FAIL) begin
                            state_nx = ST_LOCKED;
                            fail_nx  = fail_cnt + FAIL_W'(1);
                        end else begin
                            state_nx = ST_LOCKOUT;
                            fail_nx  = FAIL_W'(MAX_FAIL);
                            lko_load = 1'b1;
                        end
                    end else begin
                        state_nx    = ST_COLLECT;
                        idx_nx      = seq_idx + IDX_W'(1);
                        mismatch_nx = mismatch | key_bad_c;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (relock || !ena || unl_zero) state_nx = ST_LOCKED;
            end
            ST_LOCKOUT: begin
                if (lko_zero) begin
                    state_nx = ST_LOCKED;
                    fail_nx  = '0;
                end
            end
            default: state_nx = ST_LOCKED;
        endcase
    end

    // Loaded with N-1 so the state is held for exactly N cycles before the zero exit
    sentinel_timer #(.W(LOCK_W)) u_lko_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lko_load),
        .load_val (LOCK_W'(LOCKOUT_CYC - 1)),
        .dec      (state == ST_LOCKOUT),
        .zero_c   (lko_zero)
    );

    if (UNLOCK_CYC > 0) begin : g_unl_timer
        localparam int unsigned UNL_W = $clog2(UNLOCK_CYC + 1);
        sentinel_timer #(.W(UNL_W)) u_unl_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (unl_load),
            .load_val (UNL_W'(UNLOCK_CYC - 1)),
            .dec      (state == ST_UNLOCKED),
            .zero_c   (unl_zero)
        );
    end else begin : g_no_unl_timer
        logic unused_unl_load;
        assign unused_unl_load = unl_load;
        assign unl_zero        = 1'b0;
    end

    always_comb begin
        unlocked = (state == ST_UNLOCKED) && ena;
        lockout  = (state == ST_LOCKOUT);
        seg_out  = SegOff;
        if (ena) begin
            case (state)
                ST_LOCKED:   seg_out = SegLocked;
                ST_COLLECT:  seg_out = SegCollect;
                ST_UNLOCKED: seg_out = SegVerified;
                ST_LOCKOUT:  seg_out = SegLockout;
                default:     seg_out = SegOff;
            endcase
        end
    end

endmodule

// File: tb/tb_sentinel_seq_lock.sv
// Scoreboard bench for sentinel_seq_lock: a list-based attempt model predicts
// every cycle's outputs; a second instance covers the auto-relock build.
module tb_sentinel_seq_lock;

    localparam int unsigned KEY_W       = 8;
    localparam int unsigned SEQ_LEN     = 4;
    localparam int unsigned MAX_FAIL    = 3;
    localparam int unsigned LOCKOUT_CYC = 16;
    localparam logic [31:0] KEY_SEQ     = 32'h5AA5_3CB6;
    localparam int unsigned FAIL_W      = $clog2(MAX_FAIL + 1);
    localparam int unsigned IDX_W       = $clog2(SEQ_LEN + 1);

    typedef struct packed {
        logic              unl;
        logic              lko;
        logic [7:0]        seg;
        logic [FAIL_W-1:0] fail;
        logic [IDX_W-1:0]  idx;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic              key_valid = 1'b0;
    logic              relock = 1'b0;
    logic [7:0]        key_in = 8'h00;
    logic [7:0]        seg_out;
    logic              unlocked, lockout;
    logic [FAIL_W-1:0] fail_cnt;
    logic [IDX_W-1:0]  seq_idx;

    logic       en2 = 1'b1, kv2 = 1'b0, rl2 = 1'b0;
    logic [3:0] k2 = 4'h0;
    logic [7:0] seg2;
    logic       unl2, lko2;
    logic [1:0] fail2, idx2;

    int n_tests = 0;
    int n_fail  = 0;

    obs_t       exp_q[$];
    obs_t       mon_exp, mon_act;
    logic [7:0] m_keys[$];
    logic [7:0] exp_entry[SEQ_LEN];
    int         m_fails = 0;
    int         m_lock_left = 0;
    bit         m_unl = 1'b0;

    always #5 clk = ~clk;

    sentinel_seq_lock #(
        .KEY_W(KEY_W), .SEQ_LEN(SEQ_LEN), .KEY_SEQ(KEY_SEQ), .MAX_FAIL(MAX_FAIL),
        .LOCKOUT_CYC(LOCKOUT_CYC), .UNLOCK_CYC(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .key_in(key_in), .key_valid(key_valid),
        .relock(relock), .seg_out(seg_out), .unlocked(unlocked), .lockout(lockout),
        .fail_cnt(fail_cnt), .seq_idx(seq_idx)
    );

    sentinel_seq_lock #(
        .KEY_W(4), .SEQ_LEN(2), .KEY_SEQ(8'h6B), .MAX_FAIL(3),
        .LOCKOUT_CYC(16), .UNLOCK_CYC(8)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ena(en2), .key_in(k2), .key_valid(kv2),
        .relock(rl2), .seg_out(seg2), .unlocked(unl2), .lockout(lko2),
        .fail_cnt(fail2), .seq_idx(idx2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    // Model: an attempt is a list of entries judged as a whole once SEQ_LEN are in
    task automatic model_step(input bit kv, input logic [7:0] k, input bit rl, input bit en);
        bit ok;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_unl) begin
            if (rl || !en) m_unl = 1'b0;
        end else if (rl || !en) begin
            m_keys.delete();
        end else if (kv) begin
            m_keys.push_back(k);
            if (m_keys.size() == SEQ_LEN) begin
                ok = 1'b1;
                foreach (m_keys[i]) if (m_keys[i] != exp_entry[i]) ok = 1'b0;
                m_keys.delete();
                if (ok) begin
                    m_unl   = 1'b1;
                    m_fails = 0;
                end else begin
                    m_fails++;
                    if (m_fails == MAX_FAIL) m_lock_left = LOCKOUT_CYC;
                end
            end
        end
    endtask

    function automatic obs_t model_obs(input bit en);
        obs_t o;
        o.unl  = m_unl && en;
        o.lko  = (m_lock_left > 0);
        o.fail = FAIL_W'(m_fails);
        o.idx  = IDX_W'(m_keys.size());
        if (!en)                  o.seg = 8'hFF;
        else if (m_lock_left > 0) o.seg = 8'h8E;
        else if (m_unl)           o.seg = 8'hC1;
        else if (m_keys.size() > 0) o.seg = 8'hBF;
        else                      o.seg = 8'hC7;
        return o;
    endfunction

    task automatic step(input bit kv, input logic [7:0] k, input bit rl, input bit en);
        @(negedge clk);
        key_valid = kv;
        key_in    = k;
        relock    = rl;
        ena       = en;
        model_step(kv, k, rl, en);
        exp_q.push_back(model_obs(en));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic attempt(input logic [31:0] keys);
        for (int i = 0; i < int'(SEQ_LEN); i++) begin
            step(1'b1, keys[i*8 +: 8], 1'b0, 1'b1);
            idle(1);
        end
        idle(1);
    endtask

    // Monitor: compare the DUT against the oldest prediction after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {unlocked, lockout, seg_out, fail_cnt, seq_idx};
                n_tests++;
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL obs @%0t: got unl=%0b lko=%0b seg=%h fail=%0d idx=%0d, required unl=%0b lko=%0b seg=%h fail=%0d idx=%0d",
                             $time, mon_act.unl, mon_act.lko, mon_act.seg, mon_act.fail, mon_act.idx,
                             mon_exp.unl, mon_exp.lko, mon_exp.seg, mon_exp.fail, mon_exp.idx);
                end
            end
        end
    end

    initial begin
        int         cnt;
        logic [7:0] rk;
        for (int i = 0; i < int'(SEQ_LEN); i++) exp_entry[i] = KEY_SEQ[i*8 +: 8];

        #3;
        check("rst_seg", 32'(seg_out), 32'hC7);
        check("rst_unl", 32'(unlocked), 32'h0);
        check("rst_lko", 32'(lockout), 32'h0);
        check("rst_fail", 32'(fail_cnt), 32'h0);
        check("rst_idx", 32'(seq_idx), 32'h0);
        ena = 1'b0;
        #1;
        check("rst_seg_ena0", 32'(seg_out), 32'hFF);
        ena = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Auto-relock build: B then 6 unlocks for exactly 8 cycles
        @(negedge clk); kv2 = 1'b1; k2 = 4'hB;
        @(negedge clk); k2 = 4'h6;
        @(posedge clk); #1;
        check("dut2_latency", 32'(unl2), 32'h1);
        check("dut2_seg_u", 32'(seg2), 32'hC1);
        @(negedge clk); kv2 = 1'b0;
        cnt = 1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            if (unl2) cnt++;
        end
        check("dut2_unl_cycles", 32'(cnt), 32'd8);
        check("dut2_relock_seg", 32'(seg2), 32'hC7);

        attempt(KEY_SEQ);                 // correct sequence
        step(1'b0, 8'h00, 1'b1, 1'b1);    // relock pulse
        idle(2);
        attempt(32'h5AA5_3C00);           // first entry wrong
        attempt(32'h5AA5_3CB7);           // second failure
        attempt(KEY_SEQ);                 // success clears failures
        step(1'b0, 8'h00, 1'b1, 1'b1);
        attempt(32'h00A5_3CB6);           // one failure, no lockout
        attempt(32'h5AA5_00B6);
        attempt(32'h5A00_3CB6);           // third failure: lockout
        attempt(KEY_SEQ);                 // ignored during lockout
        idle(12);
        attempt(KEY_SEQ);                 // unlocks after expiry
        step(1'b0, 8'h00, 1'b1, 1'b1);

        step(1'b1, 8'hB6, 1'b0, 1'b1); idle(1);
        step(1'b1, 8'h3C, 1'b0, 1'b1); idle(1);
        step(1'b1, 8'hA5, 1'b1, 1'b1);    // relock beats the 3rd strobe
        idle(2);
        step(1'b1, 8'hB6, 1'b0, 1'b1);
        step(1'b1, 8'h3C, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);    // drop ena mid-sequence
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            rk = ($urandom_range(0, 3) != 0) ? exp_entry[m_keys.size()] : 8'($urandom);
            step(1'($urandom_range(0, 1)), rk, ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 14) != 0));
        end

        // Drive into lockout, then reset in the middle of it
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int t = 0; t < 8 && m_lock_left == 0; t++) begin
            if (m_unl) step(1'b0, 8'h00, 1'b1, 1'b1);
            attempt(32'h0000_0000);
        end
        idle(2);
        @(negedge clk);
        check("pre_rst_lockout", 32'(lockout), 32'(m_lock_left > 0));
        rst_n = 1'b0;
        #1;
        check("midlock_rst_lko", 32'(lockout), 32'h0);
        check("midlock_rst_seg", 32'(seg_out), 32'hC7);
        check("midlock_rst_fail", 32'(fail_cnt), 32'h0);
        m_keys.delete();
        m_fails     = 0;
        m_lock_left = 0;
        m_unl       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        attempt(KEY_SEQ);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(2);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sentinel_seq_lock.md
Name: sentinel_seq_lock

Overview:
- Parametrised successor to the single-byte Sentinel gate.
- Authenticates an ordered sequence of SEQ_LEN keys, each KEY_W bits wide, presented one per strobe.
- Counts failed attempts and enforces a timed lockout after MAX_FAIL failures; the lockout cannot be bypassed.
- Drives the active-low 7-segment display and a status "glow" line. Sits between the debounced DIP-switch/strobe front end and the display/status pins.

Parameters:
- KEY_W, 8: width of each key entry.
- SEQ_LEN, 4: number of entries per attempt; must be >= 1.
- KEY_SEQ, 32'h5AA5_3CB6: packed expected sequence, KEY_W*SEQ_LEN bits; entry 0 in the LSBs (default order B6, 3C, A5, 5A).
- MAX_FAIL, 3: failed attempts that trigger lockout; must be >= 1.
- LOCKOUT_CYC, 1024: lockout duration in clk cycles; must be >= 1.
- UNLOCK_CYC, 0: auto-relock timeout in cycles; 0 = hold UNLOCKED until relock.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  power-state enable.
- key_in  in  KEY_W  key entry, sampled only when key_valid=1.
- key_valid  in  1  single-cycle strobe from the upstream debouncer.
- relock  in  1  request to return to LOCKED.
- seg_out  out  8  {dp,g,f,e,d,c,b,a}, active low.
- unlocked  out  1  high in UNLOCKED with ena=1.
- lockout  out  1  high in LOCKOUT.
- fail_cnt  out  $clog2(MAX_FAIL+1)  failed attempts since the last success or lockout expiry.
- seq_idx  out  $clog2(SEQ_LEN+1)  number of entries consumed in the current attempt.

Behaviour:
- Reset: one clock (clk), asynchronous active-low reset (rst_n). While rst_n=0:
  - state=LOCKED, seq_idx=0, fail_cnt=0, mismatch flag=0, timers=0.
  - unlocked=0, lockout=0, seg_out=0xC7 if ena else 0xFF.
  - Reset mid-lockout clears the lockout.
- States: LOCKED, COLLECT, UNLOCKED, LOCKOUT. All transitions are registered; outputs are decoded from registered state plus ena.
- LOCKED, key_valid:
  - Compare key_in to entry 0; set mismatch if unequal.
  - seq_idx to 1; go to COLLECT, or go straight to judgement if SEQ_LEN=1.
- COLLECT, key_valid:
  - Compare to entry seq_idx and OR the result into mismatch; seq_idx+1.
- No early abort: a wrong entry never shortens the attempt. All SEQ_LEN entries are consumed before any decision, so timing does not leak which position was wrong.
- Judgement happens on the cycle of the final key_valid, registered:
  - mismatch=0: go to UNLOCKED next cycle; fail_cnt=0; load the relock timer with UNLOCK_CYC.
  - mismatch=1 and fail_cnt+1 < MAX_FAIL: go to LOCKED; fail_cnt+1.
  - mismatch=1 and fail_cnt+1 = MAX_FAIL: go to LOCKOUT; fail_cnt saturates at MAX_FAIL; load the lockout timer with LOCKOUT_CYC.
  - In every case seq_idx=0 and mismatch=0.
- Latency: unlocked rises exactly 1 cycle after the final key_valid.
- UNLOCKED:
  - key_valid is ignored.
  - relock=1, or ena=0, goes to LOCKED next cycle.
  - If UNLOCK_CYC>0, the timer decrements each cycle and reaching 0 goes to LOCKED.
- LOCKOUT:
  - key_valid and relock are ignored.
  - The timer decrements every cycle regardless of ena.
  - When the timer reaches 0, go to LOCKED with fail_cnt=0.
  - lockout is high for exactly LOCKOUT_CYC cycles.
- relock in LOCKED/COLLECT aborts the attempt: seq_idx=0, mismatch=0, no fail counted. relock wins over a simultaneous key_valid, and the key is discarded.
- ena=0:
  - COLLECT and UNLOCKED go to LOCKED next cycle (attempt aborted, no fail counted).
  - key_valid is ignored.
  - LOCKOUT continues to count down.
- seg_out:
  - ena=0: 0xFF.
  - LOCKED: 0xC7 ('L').
  - COLLECT: 0xBF ('-').
  - UNLOCKED: 0xC1 ('U').
  - LOCKOUT: 0x8E ('F').
- Keep the dummy_auth-style decoy out of this block; DPA obfuscation is instantiated at top level.

Decomposition:
- sentinel_pkg holds:
  - the state enum (2-bit);
  - segment constants SegOff=8'hFF, SegLocked=8'hC7, SegCollect=8'hBF, SegVerified=8'hC1, SegLockout=8'h8E;
  - a parameter-check helper.
- Sub-module sentinel_timer: loadable down-counter with a zero flag, parameter W. It is instantiated twice, once for lockout and once for auto-relock (the relock instance is tied off when UNLOCK_CYC=0).

Test Plan (test parameters: KEY_SEQ default, MAX_FAIL=3, LOCKOUT_CYC=16, UNLOCK_CYC=0):
- Strobe B6,3C,A5,5A -> unlocked=1 exactly 1 cycle after the 4th strobe; seg_out=0xC1; fail_cnt=0; pulse relock -> seg_out=0xC7 next cycle.
- Strobe 00,3C,A5,5A (first entry wrong) -> no state change until the 4th strobe; then LOCKED, fail_cnt=1, seq_idx=0; unlocked never asserts.
- Three wrong 4-entry attempts -> lockout=1 and seg_out=0x8E for exactly 16 cycles. Correct sequence strobed during lockout -> ignored. After expiry fail_cnt=0, and the correct sequence then unlocks.
- Two failures, then correct sequence -> unlocked, fail_cnt=0; a third failure afterwards gives fail_cnt=1, no lockout.
- Mid-sequence checks, each in its own attempt:
  - After 2 correct strobes, relock coinciding with the 3rd strobe -> seq_idx=0, fail_cnt unchanged.
  - Drop ena mid-sequence -> seg_out=0xFF, LOCKED.
  - Assert rst_n=0 mid-lockout -> LOCKED, lockout=0 immediately.
- Rebuild with UNLOCK_CYC=8, KEY_W=4, SEQ_LEN=2, KEY_SEQ=8'h6B -> strobe B,6 -> unlocked for exactly 8 cycles, then auto-relocks to 0xC7.
